// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice: default geometry of the
// instruction memory, the reset fetch index and the sequencer state encoding.
package fetch_pkg;

    localparam int FETCH_ADDR_W   = 10;  // 1024 instruction words
    localparam int FETCH_DATA_W   = 32;  // instruction width
    localparam int FETCH_RESET_PC = 0;   // first index fetched after reset

    // IDLE: no new memory reads; RUN: reads may be issued.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO holding {instruction, index} pairs between the memory return
// and decode. Flush empties it in one edge and takes priority over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int W = FETCH_DATA_W + FETCH_ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count
);

    logic [W-1:0] entry [2];
    logic         rd_ptr;
    logic         wr_ptr;

    // Head entry is presented directly; it only changes when popped or written.
    assign rd_data = entry[rd_ptr];

    // Storage, pointers and occupancy; flush drops everything queued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) entry[i] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= wr_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // The issue rule upstream must never let a word arrive with no room for it.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !flush && count == 2'd2));

endmodule

// File: rtl/insn_fetch_ctrl.sv
// Fetch sequencer: owns the instruction index driven to the memory read port,
// tracks the single read in flight (one-cycle registered memory latency) and
// queues returned words with their index for decode over valid/ready.
//
// Handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready, and
// out_insn/out_pc hold stable while out_valid=1 and out_ready=0.
module insn_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = FETCH_ADDR_W,
    parameter int DATA_W   = FETCH_DATA_W,
    parameter int RESET_PC = FETCH_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_insn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_insn,
    output logic [ADDR_W-1:0] out_pc,
    output logic              dbg_state,
    output logic [1:0]        dbg_count,
    output logic              dbg_inflight
);

    localparam logic [ADDR_W-1:0] RESET_IDX = ADDR_W'(RESET_PC);

    fetch_state_e      state;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [1:0]        count;
    logic [2:0]        occupancy;
    logic              pop;
    logic              push;
    logic              issue;

    // Words that will be held after this edge: queued + returning - leaving.
    // Keeping this below 2 guarantees the queue can always take the return.
    assign pop       = out_valid && out_ready;
    assign occupancy = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign issue     = (state == RUN) && !redirect_valid && (occupancy < 3'd2);
    assign push      = inflight && !redirect_valid;

    assign out_valid    = (count != 2'd0);
    assign dbg_state    = state;
    assign dbg_count    = count;
    assign dbg_inflight = inflight;

    // Run/idle sequencing driven only by fetch_en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (fetch_en)  state <= RUN;
                RUN:     if (!fetch_en) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Fetch index and in-flight tracking; a redirect discards the returning word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr    <= RESET_IDX;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            mem_addr <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                mem_addr    <= mem_addr + ADDR_W'(1);
                inflight_pc <= mem_addr;
            end
        end
    end

    fetch_fifo #(
        .W(DATA_W + ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data ({mem_insn, inflight_pc}),
        .rd_data ({out_insn, out_pc}),
        .count   (count)
    );

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Bench for insn_fetch_ctrl. The reference model is the architectural
// instruction stream: every accepted word must be the next sequential index
// (modulo 1024) since the last reset/redirect, carrying that index's memory word.
module tb_insn_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        out_ready;

    logic [9:0]  mem_addr,  w_mem_addr;
    logic [31:0] mem_insn,  w_mem_insn;
    logic        out_valid, w_out_valid;
    logic [31:0] out_insn,  w_out_insn;
    logic [9:0]  out_pc,    w_out_pc;
    logic        dbg_state, w_dbg_state;
    logic [1:0]  dbg_count, w_dbg_count;
    logic        dbg_inflight, w_dbg_inflight;

    logic [31:0] mem [1024];

    int          passed;
    int          total;
    int          hs_cnt;
    logic [9:0]  exp_next;
    logic [9:0]  w_got_q[$];
    logic [31:0] w_insn_q[$];
    logic [9:0]  exp_q[$];

    insn_fetch_ctrl #(.ADDR_W(10), .DATA_W(32), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_addr(mem_addr), .mem_insn(mem_insn),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_insn(out_insn), .out_pc(out_pc),
        .dbg_state(dbg_state), .dbg_count(dbg_count), .dbg_inflight(dbg_inflight)
    );

    insn_fetch_ctrl #(.ADDR_W(10), .DATA_W(32), .RESET_PC(1022)) dut_w (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_addr(w_mem_addr), .mem_insn(w_mem_insn),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_insn(w_out_insn), .out_pc(w_out_pc),
        .dbg_state(w_dbg_state), .dbg_count(w_dbg_count), .dbg_inflight(w_dbg_inflight)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: registered read port per DUT
    always @(posedge clk) begin
        mem_insn   <= mem[mem_addr];
        w_mem_insn <= mem[w_mem_addr];
    end

    function automatic logic [31:0] word_of(input logic [9:0] a);
        return 32'h1000_0000 + {22'd0, a};
    endfunction

    // One clock: scoreboard the handshake of the current cycle at the falling
    // edge, then advance to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        if (!rst_n) begin
            exp_next = 10'd0;
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (out_pc !== exp_next || out_insn !== word_of(exp_next))
                    $display("FAIL stream: got pc=%0h insn=%08h, want pc=%0h insn=%08h",
                             out_pc, out_insn, exp_next, word_of(exp_next));
                else passed++;
                hs_cnt++;
                exp_next = exp_next + 10'd1;
            end
            if (w_out_valid && out_ready) begin
                w_got_q.push_back(w_out_pc);
                w_insn_q.push_back(w_out_insn);
            end
            if (redirect_valid) exp_next = redirect_pc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        reset_dut();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_pc !== 10'd0) $display("FAIL reset_pc: got %0h want 0", out_pc); else passed++;
        total++; if (out_insn !== 32'd0) $display("FAIL reset_insn: got %08h want 0", out_insn); else passed++;
        total++; if (mem_addr !== 10'd0) $display("FAIL reset_addr: got %0h want 0", mem_addr); else passed++;
        total++; if (w_mem_addr !== 10'd1022) $display("FAIL reset_addr_w: got %0d want 1022", w_mem_addr); else passed++;
        total++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %b want IDLE", dbg_state); else passed++;
        total++; if (dbg_count !== 2'd0 || dbg_inflight !== 1'b0)
            $display("FAIL reset_queue: got count=%0d inflight=%b want 0/0", dbg_count, dbg_inflight); else passed++;
    endtask

    // Reset released with fetch_en=1 in cycle 0; first word at cycle 3, then one per cycle.
    task automatic test_first_fetch();
        rst_n = 1'b0; step(); step();
        rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            total++; if (out_valid !== 1'b0) $display("FAIL early_valid: cycle %0d got %b want 0", c, out_valid); else passed++;
            step();
            if (c == 0) begin
                total++; if (dbg_state !== RUN) $display("FAIL run_cycle1: got %b want RUN", dbg_state); else passed++;
            end
        end
        for (int c = 3; c < 23; c++) begin
            total++;
            if (out_valid !== 1'b1 || out_pc !== 10'(c - 3))
                $display("FAIL first_stream: cycle %0d got valid=%b pc=%0h want 1/%0h", c, out_valid, out_pc, 10'(c - 3));
            else passed++;
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] p;
        int h0;
        p = exp_next;
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i < 6) begin
                total++;
                if (dbg_count !== 2'd2 || mem_addr !== p + 10'd2 || out_pc !== p || out_valid !== 1'b1)
                    $display("FAIL stall: cyc %0d got count=%0d addr=%0h pc=%0h want 2/%0h/%0h",
                             i, dbg_count, mem_addr, out_pc, p + 10'd2, p);
                else passed++;
            end
        end
        out_ready = 1'b1;
        h0 = hs_cnt;
        for (int i = 0; i < 8; i++) begin
            total++; if (out_valid !== 1'b1) $display("FAIL resume_gap: cyc %0d got valid=%b want 1", i, out_valid); else passed++;
            step();
        end
        total++; if (hs_cnt - h0 !== 8) $display("FAIL resume_count: got %0d want 8", hs_cnt - h0); else passed++;
    endtask

    // Redirect while a read is in flight, with a handshake in the same cycle.
    task automatic test_redirect_inflight();
        int h0;
        total++; if (dbg_inflight !== 1'b1 || out_valid !== 1'b1)
            $display("FAIL redir_pre: got inflight=%b valid=%b want 1/1", dbg_inflight, out_valid); else passed++;
        h0 = hs_cnt;
        redirect_valid = 1'b1; redirect_pc = 10'h200;
        step();
        redirect_valid = 1'b0;
        total++; if (hs_cnt - h0 !== 1) $display("FAIL redir_hs: got %0d want 1", hs_cnt - h0); else passed++;
        for (int i = 1; i < 3; i++) begin
            total++; if (out_valid !== 1'b0) $display("FAIL redir_stale: t+%0d got valid=%b want 0", i, out_valid); else passed++;
            step();
        end
        total++; if (out_valid !== 1'b1 || out_pc !== 10'h200 || out_insn !== word_of(10'h200))
            $display("FAIL redir_t3: got valid=%b pc=%0h want 1/200", out_valid, out_pc); else passed++;
        repeat (4) step();
    endtask

    // Redirect while the queue is full and decode is stalled.
    task automatic test_redirect_full();
        out_ready = 1'b0;
        step(); step();
        total++; if (dbg_count !== 2'd2) $display("FAIL full_pre: got count=%0d want 2", dbg_count); else passed++;
        redirect_valid = 1'b1; redirect_pc = 10'h37f;
        step();
        redirect_valid = 1'b0; out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            total++; if (out_valid !== 1'b0) $display("FAIL full_stale: t+%0d got valid=%b want 0", i, out_valid); else passed++;
            step();
        end
        total++; if (out_valid !== 1'b1 || out_pc !== 10'h37f)
            $display("FAIL full_t3: got valid=%b pc=%0h want 1/37f", out_valid, out_pc); else passed++;
        repeat (4) step();
    endtask

    task automatic test_fetch_en();
        logic [9:0] p;
        int h0;
        bit seen;
        p = exp_next;
        h0 = hs_cnt;
        fetch_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 4) fetch_en = 1'b1;
            total++; if (dbg_state !== IDLE || mem_addr !== p + 10'd3)
                $display("FAIL idle_hold: cyc %0d got state=%b addr=%0h want IDLE/%0h", i, dbg_state, mem_addr, p + 10'd3);
            else passed++;
            if (i == 3) begin
                total++; if (hs_cnt - h0 !== 3) $display("FAIL drain_count: got %0d want 3", hs_cnt - h0); else passed++;
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (out_valid) seen = 1'b1; else step();
        end
        total++; if (!seen || out_pc !== p + 10'd3)
            $display("FAIL restart: got seen=%b pc=%0h want 1/%0h", seen, out_pc, p + 10'd3); else passed++;
        repeat (3) step();
    endtask

    task automatic test_reset_midstream();
        rst_n = 1'b0;
        step();
        total++; if (out_valid !== 1'b0 || out_pc !== 10'd0 || out_insn !== 32'd0)
            $display("FAIL mid_reset_out: got valid=%b pc=%0h insn=%08h want 0/0/0", out_valid, out_pc, out_insn); else passed++;
        total++; if (mem_addr !== 10'd0 || w_mem_addr !== 10'd1022)
            $display("FAIL mid_reset_addr: got %0h/%0d want 0/1022", mem_addr, w_mem_addr); else passed++;
        total++; if (dbg_state !== IDLE || dbg_count !== 2'd0 || dbg_inflight !== 1'b0)
            $display("FAIL mid_reset_state: got state=%b count=%0d inflight=%b want IDLE/0/0", dbg_state, dbg_count, dbg_inflight); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        reset_dut();
        w_got_q.delete(); w_insn_q.delete();
        exp_q = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        repeat (10) step();
        total++; if (w_got_q.size() < 4) $display("FAIL wrap_len: got %0d want >=4", w_got_q.size()); else passed++;
        for (int i = 0; i < 4 && i < w_got_q.size(); i++) begin
            total++; if (w_got_q[i] !== exp_q[i] || w_insn_q[i] !== word_of(exp_q[i]))
                $display("FAIL wrap_pc: idx %0d got pc=%0d insn=%08h want %0d", i, w_got_q[i], w_insn_q[i], exp_q[i]); else passed++;
        end
    endtask

    task automatic test_random();
        int h0;
        for (int i = 0; i < 600; i++) begin
            fetch_en       = ($urandom_range(0, 9) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 10'($urandom_range(0, 1023));
            step();
            total++; if (dbg_count > 2'd2) $display("FAIL rand_count: got %0d want <=2", dbg_count); else passed++;
        end
        fetch_en = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
        h0 = hs_cnt;
        repeat (12) step();
        total++; if (hs_cnt - h0 < 8) $display("FAIL rand_progress: got %0d want >=8", hs_cnt - h0); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = word_of(10'(i));
        passed = 0; total = 0; hs_cnt = 0; exp_next = 10'd0;
        rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_full();
        test_fetch_en();
        test_reset_midstream();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
